// File: rtl/cpu_clock_controller.sv
// cpu_clock_controller
//   Generates a slow, visible processor clock from the 50 MHz board clock.
//   The processor can free-run at one of four rates or be single-stepped
//   with a push-button. Both raw inputs are synchronised and debounced.
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   step_n     in   raw push-button, active-low, asynchronous
//   run_sw     in   raw slide switch (1 = free-run), asynchronous
//   speed_sel  in   free-run rate select, latched at each phase entry
//   cpu_clk    out  registered processor clock
//   cpu_rise   out  one-cycle pulse in the first cycle cpu_clk reads 1
//   running    out  high while free-running (RUN_HI / RUN_LO)
//   edge_count out  cpu_clk rising edges since reset, wraps at 256
//
// State    | meaning
// ---------+-------------------------------------------------------
// HALT     | cpu_clk low, waiting for run switch or a step press
// RUN_HI   | free-run high phase, HALFn cycles
// RUN_LO   | free-run low phase, HALFn cycles, then re-check run_sw
// STEP_HI  | single-step high phase, HALF3 cycles, then HALT

module cpu_clock_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HALF0           = 25000000,
  parameter int HALF1           = 2500000,
  parameter int HALF2           = 250000,
  parameter int HALF3           = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_n,
  input  logic       run_sw,
  input  logic [1:0] speed_sel,
  output logic       cpu_clk,
  output logic       cpu_rise,
  output logic       running,
  output logic [7:0] edge_count
);

  localparam int HMAX01 = (HALF0 > HALF1) ? HALF0 : HALF1;
  localparam int HMAX23 = (HALF2 > HALF3) ? HALF2 : HALF3;
  localparam int HMAX   = (HMAX01 > HMAX23) ? HMAX01 : HMAX23;
  localparam int CW     = $clog2(HMAX + 1);
  localparam int DW     = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_HALT    = 2'd0,
    S_RUN_HI  = 2'd1,
    S_RUN_LO  = 2'd2,
    S_STEP_HI = 2'd3
  } state_t;

  // synchronisers
  logic          r_step_s1, r_step_s2;
  logic          r_run_s1,  r_run_s2;
  // debouncers
  logic          r_step_db, r_step_db_q;
  logic          r_run_db;
  logic [DW-1:0] r_step_cnt, r_run_cnt;
  // FSM
  state_t        r_state;
  logic [CW-1:0] r_phase_cnt;
  logic          r_cpu_clk;
  logic          r_cpu_rise;
  logic          r_running;
  logic [7:0]    r_edge_count;

  logic          w_step_req;

  function automatic logic [CW-1:0] half_m1(input logic [1:0] sel);
    case (sel)
      2'd0:    return CW'(HALF0 - 1);
      2'd1:    return CW'(HALF1 - 1);
      2'd2:    return CW'(HALF2 - 1);
      default: return CW'(HALF3 - 1);
    endcase
  endfunction

  // Synchronisers and debouncers. The debounce counter counts consecutive
  // cycles in which the synchronised level disagrees with the accepted one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_s1   <= 1'b1;
      r_step_s2   <= 1'b1;
      r_run_s1    <= 1'b0;
      r_run_s2    <= 1'b0;
      r_step_db   <= 1'b1;
      r_step_db_q <= 1'b1;
      r_run_db    <= 1'b0;
      r_step_cnt  <= '0;
      r_run_cnt   <= '0;
    end else begin
      r_step_s1   <= step_n;
      r_step_s2   <= r_step_s1;
      r_run_s1    <= run_sw;
      r_run_s2    <= r_run_s1;
      r_step_db_q <= r_step_db;

      if (r_step_s2 != r_step_db) begin
        if (r_step_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_step_db  <= r_step_s2;
          r_step_cnt <= '0;
        end else begin
          r_step_cnt <= r_step_cnt + DW'(1);
        end
      end else begin
        r_step_cnt <= '0;
      end

      if (r_run_s2 != r_run_db) begin
        if (r_run_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_run_db  <= r_run_s2;
          r_run_cnt <= '0;
        end else begin
          r_run_cnt <= r_run_cnt + DW'(1);
        end
      end else begin
        r_run_cnt <= '0;
      end
    end
  end

  // Press = accepted level just fell; valid for exactly one cycle.
  assign w_step_req = r_step_db_q & ~r_step_db;

  // Phase counter is loaded with HALFn-1 on phase entry and the phase ends
  // on the edge where it reads 0, giving exactly HALFn cycles per phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_HALT;
      r_phase_cnt  <= '0;
      r_cpu_clk    <= 1'b0;
      r_cpu_rise   <= 1'b0;
      r_running    <= 1'b0;
      r_edge_count <= 8'd0;
    end else begin
      r_cpu_rise <= 1'b0;
      case (r_state)
        S_HALT: begin
          // run switch wins over a coincident step press
          if (r_run_db) begin
            r_state      <= S_RUN_HI;
            r_phase_cnt  <= half_m1(speed_sel);
            r_cpu_clk    <= 1'b1;
            r_cpu_rise   <= 1'b1;
            r_running    <= 1'b1;
            r_edge_count <= r_edge_count + 8'd1;
          end else if (w_step_req) begin
            r_state      <= S_STEP_HI;
            r_phase_cnt  <= CW'(HALF3 - 1);
            r_cpu_clk    <= 1'b1;
            r_cpu_rise   <= 1'b1;
            r_edge_count <= r_edge_count + 8'd1;
          end
        end
        S_RUN_HI: begin
          if (r_phase_cnt == '0) begin
            r_state     <= S_RUN_LO;
            r_phase_cnt <= half_m1(speed_sel);
            r_cpu_clk   <= 1'b0;
          end else begin
            r_phase_cnt <= r_phase_cnt - CW'(1);
          end
        end
        S_RUN_LO: begin
          if (r_phase_cnt == '0) begin
            if (r_run_db) begin
              r_state      <= S_RUN_HI;
              r_phase_cnt  <= half_m1(speed_sel);
              r_cpu_clk    <= 1'b1;
              r_cpu_rise   <= 1'b1;
              r_edge_count <= r_edge_count + 8'd1;
            end else begin
              r_state   <= S_HALT;
              r_running <= 1'b0;
            end
          end else begin
            r_phase_cnt <= r_phase_cnt - CW'(1);
          end
        end
        S_STEP_HI: begin
          if (r_phase_cnt == '0) begin
            r_state   <= S_HALT;
            r_cpu_clk <= 1'b0;
          end else begin
            r_phase_cnt <= r_phase_cnt - CW'(1);
          end
        end
        default: begin
          r_state   <= S_HALT;
          r_cpu_clk <= 1'b0;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_clk    = r_cpu_clk;
  assign cpu_rise   = r_cpu_rise;
  assign running    = r_running;
  assign edge_count = r_edge_count;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Testbench for cpu_clock_controller with small parameters.
module tb_cpu_clock_controller;

  localparam int DEB = 4;
  localparam int H0  = 2;
  localparam int H1  = 3;
  localparam int H2  = 4;
  localparam int H3  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step_n = 1'b1;
  logic       run_sw = 1'b0;
  logic [1:0] speed_sel = 2'd0;
  logic       cpu_clk;
  logic       cpu_rise;
  logic       running;
  logic [7:0] edge_count;

  cpu_clock_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .HALF0(H0), .HALF1(H1), .HALF2(H2), .HALF3(H3)
  ) dut (
    .clk(clk), .rst(rst), .step_n(step_n), .run_sw(run_sw),
    .speed_sel(speed_sel), .cpu_clk(cpu_clk), .cpu_rise(cpu_rise),
    .running(running), .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // ---------------- behavioural model ----------------
  // Inputs are seen two edges late; an accepted level follows after DEB
  // consecutive disagreeing samples. The clock is a sequence of phases,
  // each described by its level and the number of cycles left in it.
  int         half_tab [4] = '{H0, H1, H2, H3};
  bit         m_step_mid, m_step_sync, m_step_db;
  bit         m_run_mid,  m_run_sync,  m_run_db;
  int         m_step_run, m_run_run;
  bit         m_req;
  int         m_left;
  bit         m_hi, m_is_step, m_rise;
  logic [7:0] m_edge;

  function automatic bit m_running();
    return (m_left > 0) && !m_is_step;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_step_mid = 1; m_step_sync = 1; m_step_db = 1;
      m_run_mid  = 0; m_run_sync  = 0; m_run_db  = 0;
      m_step_run = 0; m_run_run = 0; m_req = 0;
      m_left = 0; m_hi = 0; m_is_step = 0; m_rise = 0; m_edge = 8'd0;
    end else begin
      m_rise = 0;
      if (m_left == 0) begin
        if (m_run_db) begin
          m_hi = 1; m_is_step = 0; m_left = half_tab[speed_sel];
          m_rise = 1; m_edge = m_edge + 8'd1;
        end else if (m_req) begin
          m_hi = 1; m_is_step = 1; m_left = H3;
          m_rise = 1; m_edge = m_edge + 8'd1;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_hi && !m_is_step) begin
            m_hi = 0; m_left = half_tab[speed_sel];
          end else if (m_hi) begin
            m_hi = 0; m_is_step = 0;
          end else if (m_run_db) begin
            m_hi = 1; m_left = half_tab[speed_sel];
            m_rise = 1; m_edge = m_edge + 8'd1;
          end
        end
      end
      m_req = 0;
      if (m_step_sync != m_step_db) begin
        m_step_run++;
        if (m_step_run == DEB) begin
          m_step_db = m_step_sync; m_step_run = 0;
          if (!m_step_db) m_req = 1;
        end
      end else m_step_run = 0;
      if (m_run_sync != m_run_db) begin
        m_run_run++;
        if (m_run_run == DEB) begin
          m_run_db = m_run_sync; m_run_run = 0;
        end
      end else m_run_run = 0;
      m_step_sync = m_step_mid; m_step_mid = step_n;
      m_run_sync  = m_run_mid;  m_run_mid  = run_sw;
    end
  end

  // ---------------- per-cycle compare + monitors ----------------
  bit prev_rise = 1'b0;
  int hi_cycles = 0;
  int rise_cnt  = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if ({cpu_clk, cpu_rise, running, edge_count} !==
          {m_hi, m_rise, m_running(), m_edge}) begin
        n_fail++;
        if (n_fail <= 25)
          $display("FAIL model_cmp t=%0t: got clk=%b rise=%b run=%b cnt=%0d, want clk=%b rise=%b run=%b cnt=%0d",
                   $time, cpu_clk, cpu_rise, running, edge_count,
                   m_hi, m_rise, m_running(), m_edge);
      end
      if (prev_rise && cpu_rise) begin
        n_fail++;
        $display("FAIL rise_twice t=%0t: cpu_rise high two cycles, required single", $time);
      end
      prev_rise = cpu_rise;
      hi_cycles += int'(cpu_clk);
      rise_cnt  += int'(cpu_rise);
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; step_n = 1'b1; run_sw = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_rise(input int budget, input string nm);
    int k = 0;
    while (cpu_rise !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    check(nm, int'(cpu_rise === 1'b1), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    tick(3);
    chk_en = 1'b1;
    check("reset_clk", int'(cpu_clk), 0);
    check("reset_cnt", int'(edge_count), 0);
    check("reset_running", int'(running), 0);

    // single step press
    do_reset();
    hi_cycles = 0; rise_cnt = 0;
    step_n = 1'b0; tick(10);
    step_n = 1'b1; tick(20);
    check("step_hi_cycles", hi_cycles, 5);
    check("step_rises", rise_cnt, 1);
    check("step_edge_count", int'(edge_count), 1);

    // bouncing key never accepted
    do_reset();
    hi_cycles = 0; rise_cnt = 0;
    step_n = 1'b0; tick(2);
    step_n = 1'b1; tick(1);
    step_n = 1'b0; tick(2);
    step_n = 1'b1; tick(15);
    check("bounce_rises", rise_cnt, 0);
    check("bounce_edge_count", int'(edge_count), 0);
    check("bounce_clk", int'(cpu_clk), 0);

    // free-run at speed 0: period 4
    do_reset();
    speed_sel = 2'd0; run_sw = 1'b1;
    wait_rise(20, "run_first_rise");
    hi_cycles = 0; rise_cnt = 0;
    tick(40);
    check("run_rises", rise_cnt, 10);
    check("run_hi_cycles", hi_cycles, 20);
    check("run_edge_count", int'(edge_count), 11);
    check("run_running", int'(running), 1);

    // drop run_sw early in a high phase at speed 3: full high + low, then halt
    speed_sel = 2'd3;
    tick(8);
    wait_rise(20, "stop_wait_rise");
    hi_cycles = 0; rise_cnt = 0;
    run_sw = 1'b0;
    tick(30);
    check("stop_hi_cycles", hi_cycles, 5);
    check("stop_rises", rise_cnt, 1);
    check("stop_running", int'(running), 0);

    // 300 presses wrap the edge counter
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step_n = 1'b0; tick(8);
      step_n = 1'b1; tick(12);
    end
    check("wrap_edge_count", int'(edge_count), 44);

    // reset in the middle of a step high phase
    step_n = 1'b0;
    wait_rise(20, "rst_wait_rise");
    tick(1);
    rst = 1'b1;
    tick(1);
    check("rst_mid_clk", int'(cpu_clk), 0);
    check("rst_mid_cnt", int'(edge_count), 0);
    check("rst_mid_rise", int'(cpu_rise), 0);
    rst = 1'b0; step_n = 1'b1;
    tick(10);

    // randomized traffic against the model
    do_reset();
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        step_n = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 14));
      end else begin
        hold--;
      end
      if ($urandom_range(0, 59) == 0) run_sw = ~run_sw;
      if ($urandom_range(0, 3) == 0) speed_sel = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
